// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
// FSM encoding, byte width and default busy timeout.
package uart_pkg;

  localparam int BYTE_W      = 8;
  localparam int BUSY_TO_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin winner selection, combinational.
// Search starts at (ptr+1) mod N and wraps.
module uart_rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] win,
  output logic          any
);

  int idx;

  // first valid requester after ptr, modulo N
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any = 1'b1;
        win = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters.
// Define UART_ARB_PKT_LOCK_EN to hold the grant until a req_last byte completes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int BUSY_TO = BUSY_TO_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [BYTE_W*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      grant_valid,
  output logic                      err_timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(BUSY_TO + 1);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     gid_q, gid_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [N_REQ-1:0]  ready_q, ready_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              gv_q, gv_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic [N_REQ-1:0]  req_eff;
  logic [IW-1:0]     win;
  logic              any;

`ifdef UART_ARB_PKT_LOCK_EN
  logic last_q, last_d;
  logic lock_q, lock_d;

  // while locked only the granted requester may win
  always_comb begin
    req_eff = req_valid;
    if (lock_q) req_eff = req_valid & (N_REQ'(1) << gid_q);
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;

  // per-byte arbitration: every valid requester competes
  always_comb begin
    req_eff = req_valid;
  end
`endif

  uart_rr_pick #(
    .N  (N_REQ),
    .PW (IW)
  ) u_pick (
    .req (req_eff),
    .ptr (ptr_q),
    .win (win),
    .any (any)
  );

  // next-state and output computation
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    gv_d    = gv_q;
    err_d   = err_q;
    start_d = 1'b0;
    ready_d = '0;
`ifdef UART_ARB_PKT_LOCK_EN
    last_d  = last_q;
    lock_d  = lock_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (any) begin
          gid_d   = win;
          data_d  = req_data[int'(win)*BYTE_W +: BYTE_W];
          start_d = 1'b1;
          ready_d = N_REQ'(1) << win;
          gv_d    = 1'b1;
`ifdef UART_ARB_PKT_LOCK_EN
          last_d  = req_last[win];
`endif
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TO - 1)) begin
          err_d   = 1'b1;
          gv_d    = 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
          lock_d  = 1'b0;
`endif
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          gv_d    = 1'b0;
          ptr_d   = gid_q;
`ifdef UART_ARB_PKT_LOCK_EN
          lock_d  = !last_q;
`endif
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(N_REQ - 1);
      gid_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      gv_q    <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      ready_q <= '0;
`ifdef UART_ARB_PKT_LOCK_EN
      last_q  <= 1'b0;
      lock_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      gv_q    <= gv_d;
      err_q   <= err_d;
      start_q <= start_d;
      ready_q <= ready_d;
`ifdef UART_ARB_PKT_LOCK_EN
      last_q  <= last_d;
      lock_q  <= lock_d;
`endif
    end
  end

  assign req_ready   = ready_q;
  assign tx_start    = start_q;
  assign tx_data     = data_q;
  assign grant_id    = gid_q;
  assign grant_valid = gv_q;
  assign err_timeout = err_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one UART transmitter (range 2..8).
REQ-002 Parameter BUSY_TO, default 8: maximum clk cycles to wait for tx_busy to rise after tx_start.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  N_REQ  per-requester byte-available flag.
REQ-006 req_data  input  8*N_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 req_last  input  N_REQ  per-requester last-byte-of-packet flag, qualified by req_valid.
REQ-008 req_ready  output  N_REQ  one-hot, single-cycle acceptance pulse to the granted requester.
REQ-009 tx_start  output  1  single-cycle start pulse to the UART transmitter.
REQ-010 tx_data  output  8  byte presented to the transmitter; stable from tx_start until tx_busy falls.
REQ-011 tx_busy  input  1  transmitter busy, high while a frame is on the line.
REQ-012 grant_id  output  $clog2(N_REQ)  index of the current or last granted requester.
REQ-013 grant_valid  output  1  high from acceptance through end of frame.
REQ-014 err_timeout  output  1  sticky flag: tx_busy failed to rise within BUSY_TO cycles.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-016 IDLE: when any req_valid is high, select the winner round-robin starting at (ptr+1) mod N_REQ, latch grant_id and its data into tx_data, and go to ISSUE next cycle.
REQ-017 ISSUE (one cycle): assert tx_start and req_ready[grant_id], set grant_valid, clear the timeout counter, and go to WAIT_BUSY.
REQ-018 WAIT_BUSY: on tx_busy=1 go to WAIT_DONE; if the counter reaches BUSY_TO first, set err_timeout, clear grant_valid and return to IDLE.
REQ-019 WAIT_DONE: on tx_busy=0 clear grant_valid, set ptr to grant_id, and return to IDLE.
REQ-020 Requesters SHALL hold req_valid, req_data and req_last stable until they see req_ready; the arbiter samples data only in IDLE.
REQ-021 Back-to-back bytes: the minimum spacing between tx_start pulses is 2 cycles after tx_busy falls (WAIT_DONE, then IDLE, then ISSUE).
REQ-022 The single-requester case SHALL grant the same requester repeatedly, with no starvation and no bubble beyond REQ-021.
REQ-023 req_valid changes while not in IDLE SHALL NOT affect the current grant.
REQ-024 The ptr arithmetic SHALL wrap modulo N_REQ; for a non-power-of-2 N_REQ, indices >= N_REQ are never granted.
REQ-025 err_timeout SHALL clear only on rst.

Reset
REQ-026 On rst: FSM=IDLE, ptr=N_REQ-1 (so requester 0 wins first), req_ready=0, tx_start=0, tx_data=0, grant_id=0, grant_valid=0, err_timeout=0, timeout counter=0.
REQ-027 Reset asserted mid-frame SHALL force all outputs to their reset values immediately; the transmitter's in-flight frame is not aborted by this block.

Configuration
REQ-028 With UART_ARB_PKT_LOCK_EN defined: after WAIT_DONE, if the latched req_last was 0, the FSM SHALL stay locked to grant_id, waiting in IDLE for that requester's req_valid only, and ignore all other requesters until a byte with req_last=1 completes.
REQ-029 With UART_ARB_PKT_LOCK_EN undefined: arbitration is per byte, req_last is ignored, and the lock logic is absent.
REQ-030 A timeout (REQ-018) SHALL release any packet lock.

Structure
REQ-031 A shared package uart_pkg SHALL hold the FSM state encoding, the byte-width constant (8), and the default BUSY_TO.
REQ-032 The round-robin selection SHALL be a combinational sub-module uart_rr_pick with inputs req vector and ptr, and outputs winner index and any-valid.

Verification
REQ-033 After reset, all 4 req_valid rise with data 0xA0..0xA3 and tx_busy is modelled at 10 cycles/frame -> tx_data order is 0xA0, 0xA1, 0xA2, 0xA3, each with one req_ready pulse.
REQ-034 Only requester 2 is valid, with 3 bytes -> grant_id=2 for all three, and tx_start pulses exactly 2 cycles after each tx_busy fall.
REQ-035 tx_busy is held at 0 after tx_start with BUSY_TO=8 -> err_timeout=1 on the 8th cycle in WAIT_BUSY, FSM returns to IDLE, and the next request is served.
REQ-036 rst is asserted during WAIT_DONE -> grant_valid, tx_start and req_ready are 0 in the same cycle, and requester 0 wins first after release.
REQ-037 With UART_ARB_PKT_LOCK_EN, requester 1 sends 0x11 and 0x12 with last=0 then 0x13 with last=1 while requester 0 is valid -> the order is 0x11, 0x12, 0x13, then requester 0; without the macro, requester 0's byte interleaves after 0x11.
